// File: rtl/s_verify.sv
// s_verify: sweeps all 256 entries of the S memory through its read port.
// It checks that the contents are either the identity (S[i]==i) or a valid
// permutation (every value 0..255 appears exactly once).
//
// Parameters:
//   CHECK_IDENTITY : 1 = identity check, 0 = permutation check
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous reset, active-high
//   en         start request, sampled only while rdy=1
//   rdy        idle, ready for a new run, results valid
//   addr       S-memory read address
//   rddata     S-memory read data (1-cycle read latency)
//   pass       last completed run found no errors
//   err_addr   index of the first failing entry of the last run
//   err_count  number of failing entries of the last run (0..256)
module s_verify #(
   parameter int unsigned CHECK_IDENTITY = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       rdy,
   output logic [7:0] addr,
   input  logic [7:0] rddata,
   output logic       pass,
   output logic [7:0] err_addr,
   output logic [8:0] err_count
);

   localparam int unsigned AW    = 8;
   localparam int unsigned CW    = 9;
   localparam int unsigned DEPTH = 256;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t           state_q, state_d;
   logic             rdy_q, rdy_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic             pass_q, pass_d;
   logic [AW-1:0]    err_addr_q, err_addr_d;
   logic [CW-1:0]    err_count_q, err_count_d;
   logic [DEPTH-1:0] seen_q, seen_d;
   logic             eval_v_q, eval_v_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic             fail_c;

   // Next-state, evaluation of the returning read data, and output updates
   always_comb begin
      state_d     = state_q;
      rdy_d       = rdy_q;
      addr_d      = addr_q;
      pass_d      = pass_q;
      err_addr_d  = err_addr_q;
      err_count_d = err_count_q;
      seen_d      = seen_q;
      fail_c      = 1'b0;
      // Index of the address issued this cycle; its data returns next cycle.
      eval_v_d    = (state_q == READ);
      idx_d       = addr_q;

      if (eval_v_q) begin
         if (CHECK_IDENTITY != 0) begin
            fail_c = (rddata != idx_q);
         end else begin
            fail_c         = seen_q[rddata];
            seen_d[rddata] = 1'b1;
         end
         if (fail_c) begin
            if (err_count_q == '0) begin
               err_addr_d = idx_q;
            end
            if (err_count_q != CW'(DEPTH)) begin
               err_count_d = err_count_q + CW'(1);
            end
         end
      end

      case (state_q)
         IDLE: begin
            if (en) begin
               state_d     = READ;
               rdy_d       = 1'b0;
               addr_d      = '0;
               pass_d      = 1'b0;
               err_addr_d  = '0;
               err_count_d = '0;
               seen_d      = '0;
            end
         end
         READ: begin
            if (addr_q == AW'(DEPTH - 1)) begin
               state_d = DRAIN;
            end else begin
               addr_d = addr_q + AW'(1);
            end
         end
         DRAIN: begin
            // Last entry is evaluated in this cycle, so use the updated count.
            state_d = IDLE;
            rdy_d   = 1'b1;
            pass_d  = (err_count_d == '0);
         end
         default: begin
            state_d = IDLE;
            rdy_d   = 1'b1;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rdy_q       <= 1'b1;
         addr_q      <= '0;
         pass_q      <= 1'b0;
         err_addr_q  <= '0;
         err_count_q <= '0;
         seen_q      <= '0;
         eval_v_q    <= 1'b0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         rdy_q       <= rdy_d;
         addr_q      <= addr_d;
         pass_q      <= pass_d;
         err_addr_q  <= err_addr_d;
         err_count_q <= err_count_d;
         seen_q      <= seen_d;
         eval_v_q    <= eval_v_d;
         idx_q       <= idx_d;
      end
   end

   assign rdy       = rdy_q;
   assign addr      = addr_q;
   assign pass      = pass_q;
   assign err_addr  = err_addr_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_s_verify.sv
// Bench for s_verify: one instance per check mode sharing one S memory.
// Expected results are queued by the stimulus; a negedge monitor pops them
// when a run completes and also checks the address sweep and run length.
module tb_s_verify;

   typedef struct {
      int d;    // 0 = permutation instance, 1 = identity instance
      bit ab;   // run is expected to be aborted by reset
      int p;
      int ea;
      int ec;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en0, en1;
   logic       rdy0, rdy1;
   logic [7:0] addr0, addr1;
   logic [7:0] rd0, rd1;
   logic       pass0, pass1;
   logic [7:0] ea0, ea1;
   logic [8:0] ec0, ec1;

   logic [7:0] mem [256];
   exp_t       q[$];
   int         n_cmp = 0;
   int         n_bad = 0;

   // monitor state per instance
   logic prev_rdy [2];
   bit   abort_f  [2];
   bit   have_last[2];
   exp_t last     [2];
   int   low_cnt  [2];
   bit   seq_bad  [2];

   always #5 clk = ~clk;

   s_verify #(.CHECK_IDENTITY(0)) dut_perm (
      .clk(clk), .rst(rst), .en(en0), .rdy(rdy0), .addr(addr0),
      .rddata(rd0), .pass(pass0), .err_addr(ea0), .err_count(ec0));

   s_verify #(.CHECK_IDENTITY(1)) dut_id (
      .clk(clk), .rst(rst), .en(en1), .rdy(rdy1), .addr(addr1),
      .rddata(rd1), .pass(pass1), .err_addr(ea1), .err_count(ec1));

   // synchronous RAM read ports, 1-cycle latency
   always @(posedge clk) begin
      rd0 <= mem[addr0];
      rd1 <= mem[addr1];
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic mon(input int d, input logic rv, input logic [7:0] a,
                      input logic p, input logic [7:0] ea, input logic [8:0] ec);
      string tag;
      int    exp_a;
      exp_t  e;
      tag = (d == 0) ? "perm" : "ident";
      if (rst === 1'b1) begin
         abort_f[d]   = 1'b1;
         have_last[d] = 1'b0;
      end else if (rv === 1'b1 && prev_rdy[d] !== 1'b1) begin
         if (abort_f[d]) begin
            chk({tag, " reset_addr"}, int'(a), 0);
            chk({tag, " reset_pass"}, int'(p), 0);
            chk({tag, " reset_err_count"}, int'(ec), 0);
            if (q.size() > 0 && q[0].d == d && q[0].ab) void'(q.pop_front());
            last[d]      = '{d, 1'b0, 0, 0, 0};
            have_last[d] = 1'b1;
         end else begin
            chk({tag, " rdy_low_cycles"}, low_cnt[d], 257);
            chk({tag, " addr_sweep"}, int'(seq_bad[d]), 0);
            if (q.size() == 0 || q[0].d != d) begin
               chk({tag, " expectation_present"}, 0, 1);
            end else begin
               e = q.pop_front();
               chk({tag, " pass"}, int'(p), e.p);
               chk({tag, " err_addr"}, int'(ea), e.ea);
               chk({tag, " err_count"}, int'(ec), e.ec);
               last[d]      = e;
               have_last[d] = 1'b1;
            end
         end
         abort_f[d] = 1'b0;
      end else if (rv === 1'b1) begin
         abort_f[d] = 1'b0;
         if (have_last[d]) begin
            if (int'(p) != last[d].p || int'(ea) != last[d].ea || int'(ec) != last[d].ec)
               chk({tag, " idle_stable"}, 0, 1);
         end
      end else if (rv === 1'b0) begin
         if (prev_rdy[d] === 1'b1) begin
            low_cnt[d] = 0;
            seq_bad[d] = 1'b0;
            chk({tag, " run_expected"}, int'(q.size() > 0 && q[0].d == d), 1);
         end
         low_cnt[d]++;
         exp_a = (low_cnt[d] > 256) ? 255 : low_cnt[d] - 1;
         if (int'(a) != exp_a || p !== 1'b0) seq_bad[d] = 1'b1;
      end
      prev_rdy[d] = rv;
   endtask

   always @(negedge clk) begin
      mon(0, rdy0, addr0, pass0, ea0, ec0);
      mon(1, rdy1, addr1, pass1, ea1, ec1);
   end

   task automatic set_en(input int d, input logic v);
      if (d == 0) en0 = v; else en1 = v;
   endtask

   task automatic wait_rdy(input int d);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge clk);
         #1;
         if ((d == 0 ? rdy0 : rdy1) === 1'b1) done = 1'b1;
      end
      if (!done) chk("run_timeout", 0, 1);
   endtask

   task automatic push(input int d, input bit ab, input int p, input int ea, input int ec);
      exp_t e;
      e = '{d, ab, p, ea, ec};
      q.push_back(e);
   endtask

   task automatic run(input int d, input int p, input int ea, input int ec);
      push(d, 1'b0, p, ea, ec);
      set_en(d, 1'b1);
      @(posedge clk);
      #1;
      set_en(d, 1'b0);
      wait_rdy(d);
      @(posedge clk);
      #1;
   endtask

   task automatic fill_identity();
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         prev_rdy[d] = 1'b0; abort_f[d] = 1'b0; have_last[d] = 1'b0;
         low_cnt[d] = 0; seq_bad[d] = 1'b0; last[d] = '{d, 1'b0, 0, 0, 0};
      end
      rst = 1'b1; en0 = 1'b0; en1 = 1'b0;
      fill_identity();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("init perm rdy", int'(rdy0), 1);
      chk("init perm addr", int'(addr0), 0);
      chk("init perm pass", int'(pass0), 0);
      chk("init perm err_count", int'(ec0), 0);
      chk("init ident rdy", int'(rdy1), 1);
      chk("init ident err_addr", int'(ea1), 0);
      @(posedge clk);
      #1;

      // identity memory, identity check
      run(1, 1, 0, 0);

      // two bad entries, then stay idle for a few cycles
      mem[17] = 8'd99;
      mem[40] = 8'd0;
      run(1, 0, 17, 2);
      repeat (5) @(posedge clk);
      #1;

      // swapped pair: a valid permutation but not the identity
      fill_identity();
      mem[3]   = 8'd250;
      mem[250] = 8'd3;
      run(0, 1, 0, 0);
      run(1, 0, 3, 2);

      // duplicate value 5 at index 200, two runs back to back with en held
      fill_identity();
      mem[200] = 8'd5;
      push(0, 1'b0, 0, 200, 1);
      push(0, 1'b0, 0, 200, 1);
      en0 = 1'b1;
      @(posedge clk);
      #1;
      wait_rdy(0);
      @(posedge clk);
      #1;
      en0 = 1'b0;
      wait_rdy(0);
      @(posedge clk);
      #1;

      // all zeros
      for (int i = 0; i < 256; i++) mem[i] = 8'd0;
      run(0, 0, 1, 255);

      // reset in the middle of a run
      fill_identity();
      push(1, 1'b1, 0, 0, 0);
      en1 = 1'b1;
      @(posedge clk);
      #1;
      en1 = 1'b0;
      repeat (98) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // en pulses during a run are ignored
      push(0, 1'b0, 1, 0, 0);
      en0 = 1'b1;
      @(posedge clk);
      #1;
      en0 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         repeat (30) @(posedge clk);
         #1;
         en0 = 1'b1;
         @(posedge clk);
         #1;
         en0 = 1'b0;
      end
      wait_rdy(0);
      repeat (4) @(posedge clk);
      #1;

      // fresh run after the abort
      run(1, 1, 0, 0);
      repeat (3) @(posedge clk);
      #1;

      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/s_verify.md
Name: s_verify

Overview:
- Read-side counterpart to the S-array initialiser. The initialiser writes S; this block reads it back.
- Sweeps all 256 entries of the 8-bit S memory through its read port and checks the contents.
- Two checks: identity (S[i]==i), or valid permutation (every value 0..255 appears exactly once).
- Used after init and after key scheduling, as a built-in self-check and a debug aid in the cracking pipeline.

Parameters:
- CHECK_IDENTITY, default 0: 0 = permutation check; 1 = identity check.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  high = idle, ready for a new run, results valid.
- addr  out  8  S-memory read address.
- rddata  in  8  S-memory read data; equals S[addr presented in the previous cycle] (synchronous RAM, 1-cycle latency).
- pass  out  1  last completed run found no errors.
- err_addr  out  8  index of the first failing entry of the last run.
- err_count  out  9  number of failing entries in the last run (0..256).

Behaviour:
- Reset (rst high at posedge), regardless of state: rdy=1, addr=0, pass=0, err_addr=0, err_count=0, seen vector cleared, state IDLE. This also aborts a run in progress; no partial results are kept.
- States:
  - IDLE: rdy=1. On en=1 at a posedge, go to READ, rdy=0, addr=0, clear pass/err_addr/err_count and the 256-bit seen vector.
  - READ: addr increments by 1 every cycle; addr 255 is the last value issued. After addr 255 the state goes to DRAIN; addr holds 255.
  - DRAIN: one cycle; captures S[255]. At the end of this cycle return to IDLE, rdy=1, and assert pass = (err_count_final==0).
- Timing: en accepted at edge E0. addr=k during cycle k+1 (k=0..255). rddata captured at the end of cycle k+2. rdy is low for exactly 257 cycles and high again in cycle 258.
- Capture pipeline: one register holds the index of the previous cycle's addr. Data for index j is evaluated in the cycle after addr=j. No bubbles: every index 0..255 is evaluated exactly once, in order.
- Identity mode: an entry fails if rddata != j.
- Permutation mode: an entry fails if seen[rddata] was already 1; then set seen[rddata]=1. With 256 entries, duplicates == missing values, so err_count is the duplicate count.
- On the first failure of a run, err_addr=j. Later failures do not change err_addr. err_count increments by 1 per failure and must not wrap; max 256 fits in 9 bits.
- pass is 0 throughout a run. pass, err_addr and err_count are stable from rdy rising until the next accepted en.
- en while rdy=0: ignored, not queued.
- en held high continuously: a new run starts on the first edge with rdy=1, giving exactly one rdy-high cycle between runs.
- The block never writes memory and has no write-enable output.

Test Plan:
- Memory preloaded S[i]=i, CHECK_IDENTITY=1, one-cycle en pulse -> addr goes 0,1,..,255 on consecutive cycles; rdy low 257 cycles; then pass=1, err_count=0.
- Identity mode, S[17]=99 and S[40]=0 -> pass=0, err_addr=17, err_count=2; outputs stable for 5 idle cycles.
- Permutation mode, identity with S[3]/S[250] swapped -> pass=1, err_count=0. Same memory in identity mode -> pass=0, err_addr=3, err_count=2.
- Permutation mode, S[200]=S[5]=5 (value 200 missing) -> pass=0, err_addr=200, err_count=1. Second back-to-back run with en held high gives the same result, confirming the seen vector is cleared between runs.
- Permutation mode, all entries 0 -> err_addr=1, err_count=255, pass=0.
- rst pulsed at cycle 100 of a run -> next cycle rdy=1, addr=0, pass=0, err_count=0. en pulses during the rest of a later run are ignored. A fresh run on an identity memory then passes.
